green_delay_gen: RTL

GREEN_DELAY_GEN -- requirements
Module: green_delay_gen

---
 rtl/green_delay_gen.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/green_delay_gen.sv
// -----------------------------------------------------------------------------
// green_delay_gen
// Adaptive green-time generator for a two-way intersection. Counts vehicles
// waiting on red for each direction and, when the opposing yellow starts,
// converts that queue into a green duration in clock cycles for the FSM.
//
// Optional feature (macro FAULT_MONITOR_EN): illegal light-combination monitor.
// When defined, an illegal combination sets a sticky fault flag. While the
// flag is set, both delays are forced to the minimum and the queues freeze.
// When undefined, the fault port is tied low and no checker logic exists.
//
// Ports
//   clk                              rising-edge clock
//   rst                              synchronous active-high reset
//   NS_RED/NS_YELLOW/NS_GREEN        north-south light state from the FSM
//   EW_RED/EW_YELLOW/EW_GREEN        east-west light state from the FSM
//   ns_car, ew_car                   one-cycle pulse per arriving vehicle
//   ns_green_delay, ew_green_delay   registered green durations (cycles)
//   ns_upd, ew_upd                   one-cycle strobe on delay rewrite
//   fault                            sticky illegal-light flag
// -----------------------------------------------------------------------------
module green_delay_gen #(
    parameter int CLK_FREQ      = 50_000_000,
    parameter int BASE_GREEN_MS = 10_000,
    parameter int PER_CAR_MS    = 2_000,
    parameter int MIN_GREEN_MS  = 5_000,
    parameter int MAX_GREEN_MS  = 60_000,
    parameter int CNT_WIDTH     = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        NS_RED,
    input  logic        NS_YELLOW,
    input  logic        NS_GREEN,
    input  logic        EW_RED,
    input  logic        EW_YELLOW,
    input  logic        EW_GREEN,
    input  logic        ns_car,
    input  logic        ew_car,
    output logic [31:0] ns_green_delay,
    output logic [31:0] ew_green_delay,
    output logic        ns_upd,
    output logic        ew_upd,
    output logic        fault
);

    // Queue length -> clamped duration in cycles. 64-bit intermediates keep
    // the product exact before the clamp for any realistic parameter set.
    function automatic logic [31:0] f_cycles(input logic [CNT_WIDTH-1:0] q);
        logic [63:0] ms;
        logic [63:0] cyc;
        ms = 64'(BASE_GREEN_MS) + 64'(PER_CAR_MS) * 64'(q);
        if (ms < 64'(MIN_GREEN_MS)) ms = 64'(MIN_GREEN_MS);
        if (ms > 64'(MAX_GREEN_MS)) ms = 64'(MAX_GREEN_MS);
        cyc = ms * 64'(CLK_FREQ / 1000);
        return cyc[31:0];
    endfunction

    localparam logic [31:0] L_BASE_CYC = f_cycles('0);
    localparam logic [31:0] L_MIN_CYC  = 32'(64'(MIN_GREEN_MS) * 64'(CLK_FREQ / 1000));

    // Light vector order: {NS_R, NS_Y, NS_G, EW_R, EW_Y, EW_G}
    logic [5:0]           w_lights;
    logic [5:0]           r_lights;
    logic [5:0]           w_rise;
    logic                 w_unused_rise;
    logic                 w_ns_y_rise;
    logic                 w_ew_y_rise;
    logic                 w_fault_now;
    logic [CNT_WIDTH-1:0] r_ns_q;
    logic [CNT_WIDTH-1:0] r_ew_q;

    assign w_lights      = {NS_RED, NS_YELLOW, NS_GREEN, EW_RED, EW_YELLOW, EW_GREEN};
    assign w_rise        = w_lights & ~r_lights;
    assign w_ns_y_rise   = w_rise[4];
    assign w_ew_y_rise   = w_rise[1];
    // Only the two yellow rises drive behaviour; the rest are kept for visibility.
    assign w_unused_rise = ^{w_rise[5], w_rise[3:2], w_rise[0]};

`ifdef FAULT_MONITOR_EN
    logic r_fault;
    logic r_armed;
    logic w_illegal;

    // Each direction must show exactly one lamp, and at least one must be red.
    assign w_illegal = !$onehot({NS_RED, NS_YELLOW, NS_GREEN})
                     | !$onehot({EW_RED, EW_YELLOW, EW_GREEN})
                     | (!NS_RED && !EW_RED);

    // The checker is armed from the second cycle after reset release, so the
    // FSM gets one cycle to settle its outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fault <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            r_armed <= 1'b1;
            if (r_armed && w_illegal) r_fault <= 1'b1;
        end
    end

    // Force the safe state in the detection cycle, so the forced delays
    // appear together with the flag.
    assign w_fault_now = r_fault | (r_armed & w_illegal);
    assign fault       = r_fault;
`else
    assign w_fault_now = 1'b0;
    assign fault       = 1'b0;
`endif

    // NOTE: every register is written with non-blocking assignments, so all
    // branches see pre-edge values of r_ns_q/r_ew_q and r_lights. The reset is
    // synchronous and tested first inside the clocked block.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lights       <= '0;
            r_ns_q         <= '0;
            r_ew_q         <= '0;
            ns_upd         <= 1'b0;
            ew_upd         <= 1'b0;
            ns_green_delay <= L_BASE_CYC;
            ew_green_delay <= L_BASE_CYC;
        end else begin
            r_lights <= w_lights;
            ns_upd   <= 1'b0;
            ew_upd   <= 1'b0;

            if (w_fault_now) begin
                ns_green_delay <= L_MIN_CYC;
                ew_green_delay <= L_MIN_CYC;
            end else begin
                // The NS queue is consumed when EW goes yellow. A car arriving
                // in that same cycle starts the next queue.
                if (w_ew_y_rise) begin
                    ns_green_delay <= f_cycles(r_ns_q);
                    ns_upd         <= 1'b1;
                    r_ns_q         <= CNT_WIDTH'(ns_car);
                end else if (ns_car && !NS_GREEN && (r_ns_q != '1)) begin
                    r_ns_q <= r_ns_q + 1'b1;
                end

                if (w_ns_y_rise) begin
                    ew_green_delay <= f_cycles(r_ew_q);
                    ew_upd         <= 1'b1;
                    r_ew_q         <= CNT_WIDTH'(ew_car);
                end else if (ew_car && !EW_GREEN && (r_ew_q != '1)) begin
                    r_ew_q <= r_ew_q + 1'b1;
                end
            end
        end
    end

endmodule
